// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every non-clock/reset signal of mem_arbiter.
//   slave  : arbiter view. CPU/DMA requests and memory ack/rdata come in;
//            CPU/DMA read data, ready pulses, error and the memory command go out.
//   master : environment view (CPU, DMA engine and memory), the mirror image.
//   CPU side : iCPU_Read, iCPU_Write, iCPU_Addr, iCPU_WData, oCPU_RData, oCPU_Rdy
//   DMA side : iDMA_Read, iDMA_Write, iDMA_Addr, iDMA_WData, oDMA_RData, oDMA_Rdy
//   Memory   : oMem_Req, oMem_We, oMem_Addr, oMem_WData, iMem_Ack, iMem_RData
//   Status   : oErr
interface mem_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              iCPU_Read;
   logic              iCPU_Write;
   logic [ADDR_W-1:0] iCPU_Addr;
   logic [DATA_W-1:0] iCPU_WData;
   logic [DATA_W-1:0] oCPU_RData;
   logic              oCPU_Rdy;

   logic              iDMA_Read;
   logic              iDMA_Write;
   logic [ADDR_W-1:0] iDMA_Addr;
   logic [DATA_W-1:0] iDMA_WData;
   logic [DATA_W-1:0] oDMA_RData;
   logic              oDMA_Rdy;

   logic              oMem_Req;
   logic              oMem_We;
   logic [ADDR_W-1:0] oMem_Addr;
   logic [DATA_W-1:0] oMem_WData;
   logic              iMem_Ack;
   logic [DATA_W-1:0] iMem_RData;

   logic              oErr;

   modport slave (
      input  iCPU_Read, iCPU_Write, iCPU_Addr, iCPU_WData,
      output oCPU_RData, oCPU_Rdy,
      input  iDMA_Read, iDMA_Write, iDMA_Addr, iDMA_WData,
      output oDMA_RData, oDMA_Rdy,
      output oMem_Req, oMem_We, oMem_Addr, oMem_WData,
      input  iMem_Ack, iMem_RData,
      output oErr
   );

   modport master (
      output iCPU_Read, iCPU_Write, iCPU_Addr, iCPU_WData,
      input  oCPU_RData, oCPU_Rdy,
      output iDMA_Read, iDMA_Write, iDMA_Addr, iDMA_WData,
      input  oDMA_RData, oDMA_Rdy,
      input  oMem_Req, oMem_We, oMem_Addr, oMem_WData,
      output iMem_Ack, iMem_RData,
      input  oErr
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one variable-latency memory port between the CPU Control unit and
//   a DMA/IO engine. Each access runs IDLE -> BUSY -> RESP -> IDLE: the
//   winner's command is latched in IDLE, held on the memory port through
//   BUSY until iMem_Ack or timeout, and a one-cycle Rdy (plus oErr on
//   timeout) is returned to the owner in RESP. All outputs are registered.
// Ports
//   iClk : clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (CPU, DMA and memory-side signals)
// Parameters
//   DATA_W, ADDR_W : bus widths
//   TIMEOUT        : BUSY cycles without ack before abort (1..255)
//   CPU_STREAK     : consecutive CPU grants while DMA waits before DMA is forced ahead
module mem_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned CPU_STREAK = 4
) (
   input logic          iClk,
   input logic          nRst,
   mem_arbiter_if.slave bus
);

   localparam int unsigned SW = $clog2(CPU_STREAK + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t            state_q;
   logic              owner_dma_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              req_q;
   logic [7:0]        tcnt_q;
   logic [SW-1:0]     streak_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              cpu_rdy_q;
   logic              dma_rdy_q;
   logic              err_q;

   logic              cpu_pend;
   logic              dma_pend;
   logic              dma_win;
   logic [SW-1:0]     streak_d;

   // Winner selection and the streak value applied at the next IDLE grant.
   always_comb begin
      cpu_pend = bus.iCPU_Read | bus.iCPU_Write;
      dma_pend = bus.iDMA_Read | bus.iDMA_Write;
      dma_win  = dma_pend && (!cpu_pend || streak_q == SW'(CPU_STREAK));
      streak_d = streak_q;
      if (dma_win || !dma_pend) begin
         streak_d = '0;
      end else if (streak_q != SW'(CPU_STREAK)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= ST_IDLE;
         owner_dma_q <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_q       <= 1'b0;
         tcnt_q      <= '0;
         streak_q    <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         cpu_rdy_q   <= 1'b0;
         dma_rdy_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // Rdy/oErr are single-cycle pulses raised only on entry to RESP.
         cpu_rdy_q <= 1'b0;
         dma_rdy_q <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cpu_pend || dma_pend) begin
                  owner_dma_q <= dma_win;
                  if (dma_win) begin
                     addr_q  <= bus.iDMA_Addr;
                     wdata_q <= bus.iDMA_WData;
                     we_q    <= bus.iDMA_Write;
                  end else begin
                     addr_q  <= bus.iCPU_Addr;
                     wdata_q <= bus.iCPU_WData;
                     we_q    <= bus.iCPU_Write;
                  end
                  streak_q <= streak_d;
                  tcnt_q   <= '0;
                  req_q    <= 1'b1;
                  state_q  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               tcnt_q <= tcnt_q + 8'd1;
               // Ack is checked first so a same-cycle ack beats the timeout.
               if (bus.iMem_Ack) begin
                  if (!we_q) begin
                     if (owner_dma_q) dma_rdata_q <= bus.iMem_RData;
                     else             cpu_rdata_q <= bus.iMem_RData;
                  end
                  req_q     <= 1'b0;
                  cpu_rdy_q <= !owner_dma_q;
                  dma_rdy_q <= owner_dma_q;
                  state_q   <= ST_RESP;
               end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                  if (!we_q) begin
                     if (owner_dma_q) dma_rdata_q <= '0;
                     else             cpu_rdata_q <= '0;
                  end
                  req_q     <= 1'b0;
                  cpu_rdy_q <= !owner_dma_q;
                  dma_rdy_q <= owner_dma_q;
                  err_q     <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.oCPU_RData = cpu_rdata_q;
   assign bus.oCPU_Rdy   = cpu_rdy_q;
   assign bus.oDMA_RData = dma_rdata_q;
   assign bus.oDMA_Rdy   = dma_rdy_q;
   assign bus.oMem_Req   = req_q;
   assign bus.oMem_We    = we_q;
   assign bus.oMem_Addr  = addr_q;
   assign bus.oMem_WData = wdata_q;
   assign bus.oErr       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Stimulus pushes the expected response
//   (owner, read data, error, completion cycle) and the expected memory
//   command (we, addr, wdata, BUSY length) into queues; a negedge monitor
//   pops and compares whenever a Rdy pulse or a memory request appears.
//   A small memory responder acks after a programmable number of BUSY cycles.
module tb_mem_arbiter;

   logic iClk;
   logic nRst;

   mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   mem_arbiter #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .TIMEOUT   (15),
      .CPU_STREAK(4)
   ) dut (
      .iClk(iClk),
      .nRst(nRst),
      .bus (bus)
   );

   typedef struct {
      bit          dma;
      logic [31:0] rdata;
      bit          err;
      int unsigned lat;   // expected cycle of Rdy; 0 = not checked
   } resp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned len;   // expected number of cycles oMem_Req stays high
   } mem_t;

   resp_t       rq[$];
   mem_t        mq[$];

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cnt   = 0;

   int unsigned ack_delay = 0;
   logic [31:0] mem_data  = '0;
   int unsigned busy_cnt  = 0;

   // monitor-only state
   bit          prev_req = 1'b0;
   mem_t        cur;
   int unsigned mlen;
   bit          stable;
   logic [31:0] snap_addr, snap_wdata;
   bit          snap_we;

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   always @(posedge iClk) cnt++;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cnt);
      end
   endfunction

   // Memory responder: ack on the (ack_delay+1)-th BUSY cycle.
   always @(negedge iClk) begin
      if (bus.oMem_Req === 1'b1) begin
         busy_cnt++;
         bus.iMem_Ack = (busy_cnt == ack_delay + 1);
      end else begin
         busy_cnt     = 0;
         bus.iMem_Ack = 1'b0;
      end
      bus.iMem_RData = bus.iMem_Ack ? mem_data : ~mem_data;
   end

   // Monitor / scoreboard.
   always @(negedge iClk) begin
      resp_t e;
      if (bus.oCPU_Rdy === 1'b1 && bus.oDMA_Rdy === 1'b1)
         chk("rdy_overlap", 1, 0);
      if (bus.oCPU_Rdy === 1'b1 || bus.oDMA_Rdy === 1'b1) begin
         if (rq.size() == 0) begin
            chk("unexpected_rdy", 1, 0);
         end else begin
            e = rq.pop_front();
            chk("owner_dma", bus.oDMA_Rdy, e.dma);
            chk("rdata", e.dma ? bus.oDMA_RData : bus.oCPU_RData, e.rdata);
            chk("err", bus.oErr, e.err);
            if (e.lat != 0) chk("latency", cnt, e.lat);
         end
      end else if (bus.oErr === 1'b1) begin
         chk("err_without_rdy", 1, 0);
      end

      if (bus.oMem_Req === 1'b1 && !prev_req) begin
         if (mq.size() == 0) begin
            chk("unexpected_mem_req", 1, 0);
            cur = '{we: 1'b0, addr: '0, wdata: '0, len: 0};
         end else begin
            cur = mq.pop_front();
            chk("mem_we", bus.oMem_We, cur.we);
            chk("mem_addr", bus.oMem_Addr, cur.addr);
            chk("mem_wdata", bus.oMem_WData, cur.wdata);
         end
         mlen       = 1;
         stable     = 1'b1;
         snap_we    = bus.oMem_We;
         snap_addr  = bus.oMem_Addr;
         snap_wdata = bus.oMem_WData;
      end else if (bus.oMem_Req === 1'b1 && prev_req) begin
         mlen++;
         if (bus.oMem_We !== snap_we || bus.oMem_Addr !== snap_addr || bus.oMem_WData !== snap_wdata)
            stable = 1'b0;
      end else if (bus.oMem_Req !== 1'b1 && prev_req) begin
         chk("mem_req_len", mlen, cur.len);
         chk("mem_stable", stable, 1);
      end
      prev_req = (bus.oMem_Req === 1'b1);
   end

   task automatic wait_rdy(input int unsigned max);
      bit seen = 1'b0;
      for (int unsigned i = 0; i < max && !seen; i++) begin
         @(negedge iClk); #1;
         if (bus.oCPU_Rdy === 1'b1 || bus.oDMA_Rdy === 1'b1) seen = 1'b1;
      end
      if (!seen) chk("rdy_timeout", 0, 1);
   endtask

   task automatic drive(input bit dma, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (dma) begin
         bus.iDMA_Read = rd; bus.iDMA_Write = wr; bus.iDMA_Addr = a; bus.iDMA_WData = d;
      end else begin
         bus.iCPU_Read = rd; bus.iCPU_Write = wr; bus.iCPU_Addr = a; bus.iCPU_WData = d;
      end
   endtask

   // One isolated access: request, wait for Rdy, drop on the edge that samples it.
   task automatic access(input bit dma, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input int unsigned len, input logic [31:0] exp_rdata,
                         input bit exp_err);
      resp_t r;
      mem_t  m;
      @(posedge iClk); #1;
      drive(dma, rd, wr, a, d);
      r.dma = dma; r.rdata = exp_rdata; r.err = exp_err; r.lat = cnt + 1 + len;
      m.we = wr; m.addr = a; m.wdata = d; m.len = len;
      rq.push_back(r);
      mq.push_back(m);
      wait_rdy(40);
      @(posedge iClk); #1;
      drive(dma, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      resp_t r;
      mem_t  m;
      nRst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      bus.iMem_Ack   = 1'b0;
      bus.iMem_RData = '0;
      repeat (3) @(negedge iClk);
      chk("rst_req", bus.oMem_Req, 0);
      chk("rst_rdy", {bus.oCPU_Rdy, bus.oDMA_Rdy, bus.oErr}, 0);
      chk("rst_rdata", {bus.oCPU_RData, bus.oDMA_RData}, 0);
      chk("rst_mem_bus", {bus.oMem_We, bus.oMem_Addr, bus.oMem_WData}, 0);
      nRst = 1'b1;
      repeat (2) @(posedge iClk);

      // 1: CPU read, ack in first BUSY cycle
      ack_delay = 0; mem_data = 32'hCAFEF00D;
      access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1, 32'hCAFEF00D, 1'b0);

      // DMA read to give oDMA_RData a known value
      ack_delay = 0; mem_data = 32'h0D0D0D0D;
      access(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1, 32'h0D0D0D0D, 1'b0);

      // 2: DMA write, ack after 3 wait cycles; read data must be untouched
      ack_delay = 3; mem_data = 32'hDEADDEAD;
      access(1'b1, 1'b0, 1'b1, 32'h20, 32'h55AA, 4, 32'h0D0D0D0D, 1'b0);

      // 3: both requesting continuously -> C,C,C,C,D twice
      ack_delay = 0; mem_data = 32'h11112222;
      for (int i = 0; i < 10; i++) begin
         r.dma = (i % 5 == 4); r.rdata = 32'h11112222; r.err = 1'b0; r.lat = 0;
         m.we = 1'b0; m.addr = r.dma ? 32'h80 : 32'h40; m.wdata = 32'h0; m.len = 1;
         rq.push_back(r);
         mq.push_back(m);
      end
      @(posedge iClk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
      for (int i = 0; i < 10; i++) wait_rdy(40);
      @(posedge iClk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);

      // 4: CPU read, memory never acks -> 15-cycle timeout, rdata forced to 0
      ack_delay = 1000; mem_data = 32'h99999999;
      access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 15, 32'h0, 1'b1);

      // 6: CPU read+write together, ack on the timeout cycle -> write, no error
      ack_delay = 14; mem_data = 32'h77777777;
      access(1'b0, 1'b1, 1'b1, 32'h30, 32'h1234, 15, 32'h0, 1'b0);

      // 5: reset during BUSY of a DMA read
      ack_delay = 1000; mem_data = 32'h5A5A5A5A;
      m.we = 1'b0; m.addr = 32'h50; m.wdata = 32'h0; m.len = 3;
      mq.push_back(m);
      @(posedge iClk); #1;
      drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
      repeat (4) @(negedge iClk);
      #2 nRst = 1'b0;
      #1 chk("async_rst_req", bus.oMem_Req, 0);
      drive(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
      repeat (2) @(negedge iClk);
      chk("rst2_rdata", {bus.oCPU_RData, bus.oDMA_RData}, 0);
      chk("rst2_rdy", {bus.oCPU_Rdy, bus.oDMA_Rdy, bus.oErr}, 0);
      nRst = 1'b1;
      repeat (3) @(posedge iClk);
      ack_delay = 0; mem_data = 32'h600DF00D;
      access(1'b1, 1'b1, 1'b0, 32'h54, 32'h0, 1, 32'h600DF00D, 1'b0);

      repeat (4) @(posedge iClk);
      chk("resp_queue_empty", rq.size(), 0);
      chk("mem_queue_empty", mq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
